// File: rtl/out_layer_pkg.sv
// Shared output-layer constants: pixel width and FIFO geometry,
// used by out_layer_fifo and output_layer.
package out_layer_pkg;

    localparam int OUT_PIX_W      = 8;
    localparam int OUT_FIFO_DEPTH = 512;
    localparam int OUT_FIFO_CNT_W = 10;
    localparam int OUT_FIFO_AFULL = 500;
    localparam int OUT_PIX_CNT_W  = 16;

endpackage

// File: rtl/out_layer_fifo_ram.sv
// Simple dual-port RAM, one write port, one read port with a
// registered, synchronously cleared read output.
// Ports: clk, srst, we/waddr/wdata (write), re/raddr/rdata (read).
module out_layer_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/out_layer_fifo.sv
// Elastic pixel FIFO ahead of output_layer, with per-layer pixel count.
// Ports: clk, srst (sync, active high), start/pixels_per_layer (layer
// control), s_data/s_valid/s_ready (input stream), rd_en/dout/data_count
// (drain port), full/empty/almost_full/underflow/layer_done (status).
// Build option OUT_LAYER_FIFO_RELU_EN: clamp negative pixels to 0 on write.
module out_layer_fifo
    import out_layer_pkg::*;
#(
    parameter int DATA_WIDTH    = OUT_PIX_W,
    parameter int DEPTH         = OUT_FIFO_DEPTH,
    parameter int COUNT_WIDTH   = OUT_FIFO_CNT_W,
    parameter int AFULL_THRESH  = OUT_FIFO_AFULL,
    parameter int PIX_CNT_WIDTH = OUT_PIX_CNT_W
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     start,
    input  logic [PIX_CNT_WIDTH-1:0] pixels_per_layer,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [COUNT_WIDTH-1:0]   data_count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     underflow,
    output logic                     layer_done
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [COUNT_WIDTH-1:0]   count_nxt;
    logic                     wr_fire;
    logic                     rd_fire;
    logic [DATA_WIDTH-1:0]    wr_data;

    logic [PIX_CNT_WIDTH-1:0] pix_cnt;
    logic [PIX_CNT_WIDTH-1:0] pix_nxt;
    logic [PIX_CNT_WIDTH-1:0] pix_base;
    logic [PIX_CNT_WIDTH-1:0] ppl_q;
    logic [PIX_CNT_WIDTH-1:0] ppl_eff;
    logic                     done_base;
    logic                     done_nxt;

    // s_ready comes straight from the registered full flag.
    assign s_ready = ~full;
    assign wr_fire = s_valid & ~full;
    assign rd_fire = rd_en & ~empty;

`ifdef OUT_LAYER_FIFO_RELU_EN
    assign wr_data = s_data[DATA_WIDTH-1] ? '0 : s_data;
`else
    assign wr_data = s_data;
`endif

    out_layer_fifo_ram #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .srst  (srst),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (rd_ptr),
        .rdata (dout)
    );

    always_comb begin
        count_nxt = data_count;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_nxt = data_count + COUNT_WIDTH'(1);
            2'b01:   count_nxt = data_count - COUNT_WIDTH'(1);
            default: count_nxt = data_count;
        endcase
    end

    // Flags are computed from the next count so they line up with
    // data_count in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_count  <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            data_count  <= count_nxt;
            full        <= (count_nxt == COUNT_WIDTH'(DEPTH));
            empty       <= (count_nxt == '0);
            almost_full <= (count_nxt >= COUNT_WIDTH'(AFULL_THRESH));
        end
    end

    // A start in the same cycle as a write counts that write as the
    // first pixel of the new layer.
    always_comb begin
        ppl_eff   = start ? pixels_per_layer : ppl_q;
        pix_base  = start ? '0 : pix_cnt;
        done_base = start ? 1'b0 : layer_done;
        pix_nxt   = pix_base;
        if (wr_fire && (pix_base != '1)) begin
            pix_nxt = pix_base + PIX_CNT_WIDTH'(1);
        end
        done_nxt = done_base
                 | (wr_fire && (ppl_eff != '0) && (pix_nxt == ppl_eff));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pix_cnt    <= '0;
            ppl_q      <= '0;
            layer_done <= 1'b0;
        end else begin
            if (start) begin
                ppl_q <= pixels_per_layer;
            end
            pix_cnt    <= pix_nxt;
            layer_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_out_layer_fifo.sv
// Directed testbench for out_layer_fifo with a queue-based model
// of FIFO contents, status flags and the layer pixel counter.
module tb_out_layer_fifo;

    logic        clk;
    logic        srst;
    logic        start;
    logic [15:0] pixels_per_layer;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        rd_en;
    logic [7:0]  dout;
    logic [9:0]  data_count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        underflow;
    logic        layer_done;

    int checks;
    int failures;

    logic [7:0]  q[$];
    logic [7:0]  exp_dout;
    int          mcnt;
    logic        muf;
    logic [15:0] mpix;
    logic [15:0] mppl;
    logic        mdone;
    int          accepted;

    out_layer_fifo dut (
        .clk              (clk),
        .srst             (srst),
        .start            (start),
        .pixels_per_layer (pixels_per_layer),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .rd_en            (rd_en),
        .dout             (dout),
        .data_count       (data_count),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .underflow        (underflow),
        .layer_done       (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] relu(input logic [7:0] d);
`ifdef OUT_LAYER_FIFO_RELU_EN
        return d[7] ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        exp_dout = 8'h00;
        mcnt     = 0;
        muf      = 1'b0;
        mpix     = '0;
        mppl     = '0;
        mdone    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, data_count, mcnt);
        chk({tag, ".dout"}, dout, exp_dout);
        chk({tag, ".empty"}, empty, mcnt == 0);
        chk({tag, ".full"}, full, mcnt == 512);
        chk({tag, ".s_ready"}, s_ready, mcnt != 512);
        chk({tag, ".afull"}, almost_full, mcnt >= 500);
        chk({tag, ".underflow"}, underflow, muf);
        chk({tag, ".layer_done"}, layer_done, mdone);
    endtask

    // One clock: drive inputs, advance model, check every output.
    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic r, input logic st,
                       input logic [15:0] ppl, input string tag);
        logic acc;
        logic pop;
        s_valid          = v;
        s_data           = d;
        rd_en            = r;
        start            = st;
        pixels_per_layer = ppl;
        acc = v && (mcnt < 512);
        pop = r && (mcnt > 0);
        if (r && mcnt == 0) muf = 1'b1;
        if (pop) exp_dout = q.pop_front();
        if (acc) q.push_back(relu(d));
        mcnt = mcnt + int'(acc) - int'(pop);
        if (st) begin
            mppl  = ppl;
            mpix  = '0;
            mdone = 1'b0;
        end
        if (acc) begin
            accepted++;
            if (mpix != 16'hFFFF) mpix = mpix + 16'd1;
            if (mppl != 0 && mpix == mppl) mdone = 1'b1;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        rd_en   = 1'b0;
        start   = 1'b0;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        while (mcnt > 0) cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        accepted = 0;
        srst = 1'b1;
        start = 1'b0;
        pixels_per_layer = '0;
        s_data = '0;
        s_valid = 1'b0;
        rd_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        check_all("reset");
        chk("reset.s_ready_1", s_ready, 1'b1);
        chk("reset.empty_1", empty, 1'b1);

        for (int i = 1; i <= 5; i++)
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 16'd0, "wr5");
        chk("wr5.count5", data_count, 10'd5);
        chk("wr5.empty0", empty, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "rd5");
            chk("rd5.value", dout, 8'(i));
        end
        chk("rd5.empty1", empty, 1'b1);

        for (int i = 0; i < 512; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 16'd0, "fill");
            if (i == 498) chk("fill.afull_499", almost_full, 1'b0);
            if (i == 499) chk("fill.afull_500", almost_full, 1'b1);
        end
        chk("fill.full", full, 1'b1);
        chk("fill.s_ready0", s_ready, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 16'd0, "fill.extra");
        chk("fill.extra_count", data_count, 10'd512);

        for (int i = 0; i < 256; i++)
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "half");
        chk("half.count", data_count, 10'd256);
        for (int i = 0; i < 1000; i++)
            cyc(1'b1, 8'($urandom), 1'b1, 1'b0, 16'd0, "wrrd");
        chk("wrrd.count", data_count, 10'd256);
        drain("drain1");

        cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "uflow");
        chk("uflow.set", underflow, 1'b1);
        chk("uflow.count0", data_count, 10'd0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 16'd0, "uflow.hold");

        accepted = 0;
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'd3025, "layer.start");
        for (int n = 0; n < 20000 && accepted < 3025; n++) begin
            logic v;
            logic r;
            v = ($urandom_range(0, 9) < 7);
            r = (mcnt > 0) && ($urandom_range(0, 1) == 1);
            if (accepted == 3024 && mcnt == 512) r = 1'b1;
            cyc(v, 8'($urandom), r, 1'b0, 16'd3025, "layer");
        end
        chk("layer.done_3025", layer_done, 1'b1);
        repeat (4) cyc(1'b1, 8'h11, 1'b0, 1'b0, 16'd3025, "layer.post");
        drain("drain2");

        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'd5, "restart");
        chk("restart.clear", layer_done, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b1, 16'd1, "start_wr");
        chk("start_wr.done", layer_done, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 16'd0, "ppl0");
        repeat (3) cyc(1'b1, 8'h33, 1'b0, 1'b0, 16'd0, "ppl0.wr");
        chk("ppl0.never", layer_done, 1'b0);
        drain("drain3");

        cyc(1'b1, 8'h85, 1'b0, 1'b0, 16'd0, "relu.wr");
        cyc(1'b1, 8'h7F, 1'b0, 1'b0, 16'd0, "relu.wr");
        cyc(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, "relu.wr");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "relu.rd");
`ifdef OUT_LAYER_FIFO_RELU_EN
        chk("relu.first", dout, 8'h00);
`else
        chk("relu.first", dout, 8'h85);
`endif
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "relu.rd");
        chk("relu.second", dout, 8'h7F);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "relu.rd");
        chk("relu.third", dout, 8'h00);

        for (int i = 0; i < 7; i++)
            cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 16'd0, "pre_rst");
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 16'd0, "pre_rst.rd");
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        model_reset();
        check_all("midrst");
        chk("midrst.underflow0", underflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
